// File: rtl/dpram_param.sv
// Single-clock true dual-port RAM with registered read data, write-collision flag and optional
// zero-fill clear engine (enabled by defining DPRAM_CLEAR_EN).
module dpram_param #(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 10,
    parameter int    RDW_MODE  = 0,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_A,
    input  logic              we_A,
    input  logic [ADDR_W-1:0] addr_A,
    input  logic [DATA_W-1:0] data_A,
    output logic [DATA_W-1:0] out_A,
    output logic              vld_A,
    input  logic              req_B,
    input  logic              we_B,
    input  logic [ADDR_W-1:0] addr_B,
    input  logic [DATA_W-1:0] data_B,
    output logic [DATA_W-1:0] out_B,
    output logic              vld_B,
    output logic              coll,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int HALF  = DEPTH / 2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_active;
    logic [ADDR_W-1:0] clr_addr_e, clr_addr_o;

`ifdef DPRAM_CLEAR_EN
    // state    | meaning
    // ST_IDLE  | user accesses only, waiting for clr_req
    // ST_CLEAR | zero-filling one even/odd address pair per cycle
    // ST_DONE  | one-cycle clr_done pulse, user accesses accepted
    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_e;

    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(HALF - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (clr_req) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_K) state_d = ST_DONE;
                else                 cnt_d   = cnt_q + 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign clr_active = (state_q == ST_CLEAR);
    assign clr_busy   = clr_active;
    assign clr_done   = (state_q == ST_DONE);
    assign clr_addr_e = cnt_q << 1;
    assign clr_addr_o = clr_addr_e | ADDR_W'(1);
`else
    logic unused_clr_req;
    assign unused_clr_req = clr_req;
    assign clr_active     = 1'b0;
    assign clr_busy       = 1'b0;
    assign clr_done       = 1'b0;
    assign clr_addr_e     = '0;
    assign clr_addr_o     = '0;
`endif

    logic              acc_a, acc_b, wr_a, wr_b, coll_d;
    logic              mem_we_a, mem_we_b;
    logic [ADDR_W-1:0] mem_addr_a, mem_addr_b;
    logic [DATA_W-1:0] mem_din_a, mem_din_b;
    logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic              vld_a_q, vld_b_q, coll_q;

    always_comb begin
        acc_a  = req_A & ~clr_active;
        acc_b  = req_B & ~clr_active;
        wr_a   = acc_a & we_A;
        wr_b   = acc_b & we_B;
        coll_d = wr_a & wr_b & (addr_A == addr_B);

        mem_we_a   = clr_active | wr_a;
        mem_addr_a = clr_active ? clr_addr_e : addr_A;
        mem_din_a  = clr_active ? '0 : data_A;
        // On a write-write collision port A owns the location.
        mem_we_b   = clr_active | (wr_b & ~coll_d);
        mem_addr_b = clr_active ? clr_addr_o : addr_B;
        mem_din_b  = clr_active ? '0 : data_B;

        out_a_d = out_a_q;
        if (acc_a) begin
            if (wr_a && RDW_MODE == 0) out_a_d = data_A;
            else                       out_a_d = mem[addr_A];
        end
        out_b_d = out_b_q;
        if (acc_b) begin
            if (wr_b && RDW_MODE == 0) out_b_d = coll_d ? data_A : data_B;
            else                       out_b_d = mem[addr_B];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_b) mem[mem_addr_b] <= mem_din_b;
        if (mem_we_a) mem[mem_addr_a] <= mem_din_a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a_q <= '0;
            out_b_q <= '0;
            vld_a_q <= 1'b0;
            vld_b_q <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            vld_a_q <= acc_a;
            vld_b_q <= acc_b;
            coll_q  <= coll_d;
        end
    end

    assign out_A = out_a_q;
    assign out_B = out_b_q;
    assign vld_A = vld_a_q;
    assign vld_B = vld_b_q;
    assign coll  = coll_q;
endmodule

// File: tb/tb_dpram_param.sv
// Directed bench for dpram_param: a write-first and a read-first instance share one stimulus stream;
// clear-engine checks follow whichever DPRAM_CLEAR_EN build is being compiled.
module tb_dpram_param;
    localparam int DW = 16;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_A = 0, we_A = 0, req_B = 0, we_B = 0, clr_req = 0;
    logic [AW-1:0] addr_A = '0, addr_B = '0;
    logic [DW-1:0] data_A = '0, data_B = '0;
    logic [DW-1:0] out_A0, out_B0, out_A1, out_B1;
    logic          vld_A0, vld_B0, vld_A1, vld_B1, coll0, coll1, busy0, busy1, done0, done1;

    int nvec = 0;
    int nerr = 0;

    dpram_param #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_A(req_A), .we_A(we_A), .addr_A(addr_A), .data_A(data_A), .out_A(out_A0), .vld_A(vld_A0),
        .req_B(req_B), .we_B(we_B), .addr_B(addr_B), .data_B(data_B), .out_B(out_B0), .vld_B(vld_B0),
        .coll(coll0), .clr_req(clr_req), .clr_busy(busy0), .clr_done(done0)
    );

    dpram_param #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_A(req_A), .we_A(we_A), .addr_A(addr_A), .data_A(data_A), .out_A(out_A1), .vld_A(vld_A1),
        .req_B(req_B), .we_B(we_B), .addr_B(addr_B), .data_B(data_B), .out_B(out_B1), .vld_B(vld_B1),
        .coll(coll1), .clr_req(clr_req), .clr_busy(busy1), .clr_done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_A = r; we_A = w; addr_A = a; data_A = d;
    endtask

    task automatic set_b(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_B = r; we_B = w; addr_B = a; data_B = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic saw_vld, saw_done;

        step();
        chk("rst_out", {out_A0, out_B0}, 32'h0);
        chk("rst_flags", {27'h0, vld_A0, vld_B0, coll0, busy0, done0}, 32'h0);
        chk("rst_out_rf", {out_A1, out_B1}, 32'h0);
        rst_n = 1'b1;

        // First edge after reset release: seed both ends of the array
        set_a(1, 1, 10'd1023, 16'hBEEF); set_b(1, 1, 10'd0, 16'h00AA); step();
        chk("first_vld", {30'h0, vld_A0, vld_B0}, 32'h3);

        set_a(1, 1, 10'd5, 16'h1234); set_b(0, 0, 10'd0, 16'h0); step();
        chk("wf_wr_out", out_A0, 32'h1234);
        chk("wr_vld", vld_A0, 32'h1);
        set_a(0, 0, 10'd0, 16'h0); set_b(1, 0, 10'd5, 16'h0); step();
        chk("rd_b_out", out_B0, 32'h1234);
        chk("rd_b_vld", {30'h0, vld_A0, vld_B0}, 32'h1);
        chk("hold_a", out_A0, 32'h1234);
        set_b(0, 0, 10'd0, 16'h0); step();
        chk("idle_vld", vld_B0, 32'h0);
        chk("idle_hold_b", out_B0, 32'h1234);

        set_a(1, 1, 10'd7, 16'hAAAA); step();
        set_a(1, 1, 10'd7, 16'h5555); step();
        chk("rf_wr_out", out_A1, 32'hAAAA);
        chk("wf_wr_out2", out_A0, 32'h5555);
        set_a(1, 0, 10'd7, 16'h0); step();
        chk("rf_rd", out_A1, 32'h5555);
        chk("wf_rd", out_A0, 32'h5555);

        set_a(1, 1, 10'd7, 16'h0F0F); set_b(1, 0, 10'd7, 16'h0); step();
        chk("xport_wf", out_B0, 32'h5555);
        chk("xport_rf", out_B1, 32'h5555);
        chk("xport_nocoll", coll0, 32'h0);

        set_a(1, 1, 10'd3, 16'h1111); set_b(1, 1, 10'd3, 16'h2222); step();
        chk("coll_wf", coll0, 32'h1);
        chk("coll_rf", coll1, 32'h1);
        chk("coll_vld", {30'h0, vld_A0, vld_B0}, 32'h3);
        chk("coll_outb", out_B0, 32'h1111);
        chk("coll_outa", out_A0, 32'h1111);
        set_a(0, 0, 10'd0, 16'h0); set_b(1, 0, 10'd3, 16'h0); step();
        chk("coll_pulse", coll0, 32'h0);
        chk("coll_stored", out_B0, 32'h1111);
        chk("coll_stored_rf", out_B1, 32'h1111);

        set_a(1, 1, 10'd8, 16'h0808); set_b(1, 1, 10'd9, 16'h0909); step();
        chk("diff_nocoll", coll0, 32'h0);
        set_a(1, 0, 10'd9, 16'h0); set_b(1, 0, 10'd8, 16'h0); step();
        chk("diff_a", out_A0, 32'h0909);
        chk("diff_b", out_B0, 32'h0808);
        set_a(1, 0, 10'd0, 16'h0); set_b(1, 0, 10'd1023, 16'h0); step();
        chk("edge_lo", out_A0, 32'h00AA);
        chk("edge_hi", out_B0, 32'hBEEF);

`ifdef DPRAM_CLEAR_EN
        // Clear request and user read in the same idle cycle
        set_a(1, 0, 10'd1023, 16'h0); set_b(0, 0, 10'd0, 16'h0); clr_req = 1; step();
        chk("clr_same_vld", vld_A0, 32'h1);
        chk("clr_same_out", out_A0, 32'hBEEF);
        chk("clr_busy_on", busy0, 32'h1);
        set_a(1, 0, 10'd0, 16'h0); set_b(1, 0, 10'd1, 16'h0);
        n = 1; saw_vld = 0; saw_done = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (n >= 3) clr_req = 0;
            if (!busy0) break;
            n++;
            saw_vld  = saw_vld | vld_A0 | vld_B0;
            saw_done = saw_done | done0;
        end
        chk("clr_len", n, 32'd512);
        chk("clr_busy_novld", saw_vld, 32'h0);
        chk("clr_busy_nodone", saw_done, 32'h0);
        chk("clr_done", done0, 32'h1);
        chk("clr_last_novld", vld_A0, 32'h0);
        step();
        chk("clr_done_pulse", {31'h0, done0}, 32'h0);
        chk("post_clr_vld", {30'h0, vld_A0, vld_B0}, 32'h3);
        chk("post_clr_rd", {out_A0, out_B0}, 32'h0);
        set_a(1, 0, 10'd1023, 16'h0); step();
        chk("post_clr_hi", out_A0, 32'h0);
        chk("no_restart", busy0, 32'h0);

        // Reset partway through a clear
        set_a(1, 1, 10'd1023, 16'hCAFE); set_b(1, 1, 10'd0, 16'h1357); step();
        set_a(0, 0, 10'd0, 16'h0); set_b(0, 0, 10'd0, 16'h0); clr_req = 1; step();
        chk("clr2_busy", busy0, 32'h1);
        clr_req = 0;
        repeat (99) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_flags", {30'h0, busy0, done0}, 32'h0);
        chk("midrst_out", out_A0, 32'h0);
        step();
        chk("midrst_nodone", done0, 32'h0);
        rst_n = 1'b1;
        set_a(1, 0, 10'd0, 16'h0); set_b(1, 0, 10'd1023, 16'h0); step();
        chk("midrst_vld", {30'h0, vld_A0, vld_B0}, 32'h3);
        chk("midrst_lo", out_A0, 32'h0);
        chk("midrst_hi", out_B0, 32'hCAFE);
        saw_done = 0;
        repeat (3) begin
            step();
            saw_done = saw_done | done0 | busy0;
        end
        chk("midrst_quiet", saw_done, 32'h0);
`else
        clr_req = 1; set_a(1, 0, 10'd1023, 16'h0); set_b(0, 0, 10'd0, 16'h0); step();
        chk("noclr_flags", {30'h0, busy0, done0}, 32'h0);
        chk("noclr_vld", vld_A0, 32'h1);
        chk("noclr_out", out_A0, 32'hBEEF);
        clr_req = 0; set_a(1, 0, 10'd0, 16'h0); step();
        chk("noclr_flags2", {30'h0, busy0, done0}, 32'h0);
        chk("noclr_mem", out_A0, 32'h00AA);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
